// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: buffers pixel bytes and sequences UART transmitter starts via a tx_ready handshake
module uart_tx_scheduler #(
  parameter int DEPTH       = 16,
  parameter int FRAME_BYTES = 4096,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   tx_enable,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow,
  output logic                   timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(FRAME_BYTES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] BLAST = BW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_t;
  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic [BW-1:0] bytes_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    tx_data_q;
  logic          tx_start_q, busy_q, frame_done_q, overflow_q, timeout_q;
  logic          pop, push, done;
  // Launch/accept decisions; a full FIFO still accepts when the head leaves this cycle
  always_comb begin
    pop     = (state_q == IDLE) && tx_enable && tx_ready && (count_q != '0);
    push    = in_valid && ((count_q != FULL) || pop);
    done    = tx_ready && ((state_q == WAIT_DONE) || ((state_q == START) && (timer_q == TLAST)));
    count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end
  // Byte storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end
  // FIFO pointers, occupancy and sticky overflow on a dropped push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_q + AW'(push);
      rptr_q     <= rptr_q + AW'(pop);
      count_q    <= count_d;
      overflow_q <= overflow_q | (in_valid & ~push);
    end
  end
  // Transmit sequencer: pop, set up data, hold start until acked or timed out, await idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      busy_q <= 1'b1;
      case (state_q)
        IDLE:
          if (pop) begin
            tx_data_q <= mem_q[rptr_q];
            state_q   <= LOAD;
          end else busy_q <= count_d != '0;
        LOAD: begin
          tx_start_q <= 1'b1;
          timer_q    <= '0;
          state_q    <= START;
        end
        START:
          if (!tx_ready) begin
            tx_start_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end else if (timer_q == TLAST) begin
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b1;
            state_q    <= IDLE;
            busy_q     <= count_d != '0;
          end else timer_q <= timer_q + TW'(1);
        WAIT_DONE:
          if (tx_ready) begin
            state_q <= IDLE;
            busy_q  <= count_d != '0;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Per-frame byte counter; timed-out bytes count as sent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bytes_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= done && (bytes_q == BLAST);
      if (done) bytes_q <= (bytes_q == BLAST) ? '0 : bytes_q + BW'(1);
    end
  end
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign fifo_count = count_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sequences the UART transmitter for the pixel return path.
- Buffers filtered pixel bytes produced on the UART clock and launches one transmitter start per byte using a tx_ready handshake. This replaces the ad-hoc combinational start logic in the top level.
- Gates transmission on a release signal, which is driven from the pixel-count-complete flag.
- Counts bytes per frame and flags frame completion, FIFO overflow and handshake timeouts.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of 2, range 2..256.
- FRAME_BYTES, 4096, bytes per frame; frame_done fires after this many transmitted bytes.
- ACK_TIMEOUT, 64, clocks to wait for tx_ready to fall after tx_start rises before declaring a timeout.

Ports:
- clk  input  1  UART bit clock (same clock as the transmitter and receiver).
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  pixel byte from the filter.
- in_valid  input  1  one-cycle strobe; in_data is valid this cycle.
- tx_enable  input  1  release gate; no new byte is launched while low.
- tx_ready  input  1  from the transmitter; high = idle and able to accept a start.
- tx_data  output  8  byte presented to the transmitter.
- tx_start  output  1  start request to the transmitter.
- fifo_count  output  log2(DEPTH)+1  current FIFO occupancy.
- busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- frame_done  output  1  one-cycle pulse when byte FRAME_BYTES of a frame completes.
- overflow  output  1  sticky; set when a push is dropped on a full FIFO.
- timeout  output  1  sticky; set when ACK_TIMEOUT expires.

Behaviour:
- Reset (rst=0, asynchronous): clears the FIFO pointers and count, the byte counter, the timeout counter, overflow and timeout. Sets tx_start=0, tx_data=0, frame_done=0, busy=0, and FSM=IDLE. If asserted mid-byte, tx_start drops immediately and the in-flight byte is abandoned.
- FIFO push:
  - On in_valid with count<DEPTH, or with count==DEPTH and a pop in the same cycle, write in_data.
  - Otherwise drop the byte and set overflow.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, START, WAIT_DONE.
- IDLE: when tx_enable=1, FIFO non-empty and tx_ready=1, pop the head into tx_data and go to LOAD. tx_data is registered and stable from LOAD until the next pop.
- LOAD: one cycle of data setup; then go to START with tx_start=1.
- START: hold tx_start=1 and increment the timeout counter.
  - When tx_ready=0 (acknowledged): tx_start=0, go to WAIT_DONE.
  - When the counter reaches ACK_TIMEOUT: set timeout, tx_start=0, count the byte as sent, go to IDLE.
- WAIT_DONE: wait for tx_ready=1.
  - Then increment the byte counter and go to IDLE.
  - If the counter reaches FRAME_BYTES, pulse frame_done for 1 cycle and reset the counter to 0.
- tx_enable falling: affects only the IDLE launch decision. A byte already in LOAD, START or WAIT_DONE completes normally.
- Throughput: at most one byte per transmitter frame. Minimum gap from tx_ready rising to the next tx_start is 2 clocks (IDLE pop, then LOAD).
- Empty FIFO: stay in IDLE with tx_start=0. A byte pushed while in IDLE is launchable on the next clock.
- Byte counter width: clog2(FRAME_BYTES+1). It is not reset by tx_enable, only by rst or a frame_done wrap.
- fifo_count and busy are registered; they reflect the state after the current edge.

Test Plan:
- Reset and idle: hold rst=0 with in_valid pulsing → tx_start=0, fifo_count=0, overflow=0. Release rst with tx_enable=0 and push 3 bytes → fifo_count=3, no tx_start.
- Ordered drain: push 0xA5, 0x3C, 0xFF; tx_enable=1; transmitter model drops tx_ready 1 clock after tx_start and holds it low 10 clocks → tx_data sequence is A5, 3C, FF; exactly 3 tx_start pulses; fifo_count returns to 0.
- Full FIFO: with DEPTH=4, tx_enable=0, push 5 bytes → fifo_count=4, overflow=1, the 5th byte is absent from the drained stream. Then push on a full FIFO in the same cycle as a pop → accepted, count stays 4.
- Frame counting: with FRAME_BYTES=8, stream 16 bytes → frame_done pulses exactly twice, each 1 clock wide, in the cycle after the 8th and 16th tx_ready rise.
- Timeout: tx_ready stuck at 1 after start → tx_start held for 64 clocks, then timeout=1, FSM returns to IDLE, and the next byte launches.
- Mid-operation reset: assert rst during WAIT_DONE with 2 bytes queued → tx_start=0 and fifo_count=0 asynchronously. After release, nothing is transmitted until new pushes arrive.
